// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and counter sizing.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (longint unsigned p = 1; p < longint'(v); p = p * 2) r++;
    return r;
  endfunction

  // Bit counter needs at least one bit even when n == 1.
  function automatic int unsigned cnt_width(input int unsigned v);
    return (v > 1) ? clog2(v) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus for the serial subtractor.
interface serial_subtractor_if #(
  parameter int unsigned n = 16
);
  logic         start;
  logic [n-1:0] a;
  logic [n-1:0] b;
  logic [n-1:0] diff;
  logic         borrow_out;
  logic         busy;
  logic         done;

  modport master (output start, a, b, input diff, borrow_out, busy, done);
  modport slave  (input start, a, b, output diff, borrow_out, busy, done);
endinterface

// File: rtl/serial_subtractor_full_adder.sv
// One-bit full-adder cell; purely combinational.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic sum_c,
  output logic carry_c
);
  assign sum_c   = a ^ b ^ ci;
  assign carry_c = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, through one full-adder cell with inverted b and
// carry-in forced to 1; start/busy/done handshake, results held until next completion.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned n = 16
) (
  input logic                clk,
  input logic                rst_n,
  serial_subtractor_if.slave bus
);

  localparam int unsigned CW = cnt_width(n);

  state_t          state, state_next;
  logic [n-1:0]    sa, sb, sr, sr_shift;
  logic            c, c_next, s_bit;
  logic [CW-1:0]   cnt;
  logic            last;
  logic [n-1:0]    diff_q;
  logic            borrow_q, busy_q, done_q;

  full_adder u_fa (
    .a       (sa[0]),
    .b       (~sb[0]),
    .ci      (c),
    .sum_c   (s_bit),
    .carry_c (c_next)
  );

  assign last = (cnt == CW'(n - 1));

  // Result register shifts right, new bit enters at the MSB.
  always_comb begin
    sr_shift        = sr >> 1;
    sr_shift[n-1]   = s_bit;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = SHIFT;
      SHIFT:   if (last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Datapath and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa       <= '0;
      sb       <= '0;
      sr       <= '0;
      c        <= 1'b0;
      cnt      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      busy_q <= (state_next == SHIFT);
      done_q <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (bus.start) begin
            sa  <= bus.a;
            sb  <= bus.b;
            c   <= 1'b1;
            cnt <= '0;
          end
        end
        SHIFT: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          sr  <= sr_shift;
          c   <= c_next;
          cnt <= cnt + CW'(1);
          if (last) begin
            diff_q   <= sr_shift;
            borrow_q <= ~c_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed plus random checks of serial_subtractor at n=16 and n=1 against plain arithmetic.
module tb_serial_subtractor;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  serial_subtractor_if #(.n(16)) bus16 ();
  serial_subtractor_if #(.n(1))  bus1 ();

  serial_subtractor #(.n(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  serial_subtractor #(.n(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run16(input logic [15:0] av, input logic [15:0] bv);
    int cyc, nb;
    logic [15:0] ed;
    ed = av - bv;
    @(negedge clk);
    bus16.start = 1'b1; bus16.a = av; bus16.b = bv;
    @(negedge clk);
    bus16.start = 1'b0; bus16.a = 16'($urandom); bus16.b = 16'($urandom);
    cyc = 0; nb = 0;
    while (bus16.done !== 1'b1 && cyc < 40) begin
      if (bus16.busy === 1'b1) nb++;
      @(negedge clk);
      cyc++;
    end
    chk("done16_seen", 32'(bus16.done), 32'd1);
    chk("busy16_len", 32'(nb), 32'd16);
    chk("busy16_in_done", 32'(bus16.busy), 32'd0);
    chk("diff16", 32'(bus16.diff), 32'(ed));
    chk("borrow16", 32'(bus16.borrow_out), 32'(av < bv));
    @(negedge clk);
    chk("done16_one_cycle", 32'(bus16.done), 32'd0);
  endtask

  task automatic run1(input logic av, input logic bv);
    int cyc, nb;
    logic ed;
    ed = av ^ bv;
    @(negedge clk);
    bus1.start = 1'b1; bus1.a = av; bus1.b = bv;
    @(negedge clk);
    bus1.start = 1'b0; bus1.a = 1'($urandom); bus1.b = 1'($urandom);
    cyc = 0; nb = 0;
    while (bus1.done !== 1'b1 && cyc < 10) begin
      if (bus1.busy === 1'b1) nb++;
      @(negedge clk);
      cyc++;
    end
    chk("done1_seen", 32'(bus1.done), 32'd1);
    chk("busy1_len", 32'(nb), 32'd1);
    chk("diff1", 32'(bus1.diff), 32'(ed));
    chk("borrow1", 32'(bus1.borrow_out), 32'(av < bv));
    @(negedge clk);
    chk("done1_one_cycle", 32'(bus1.done), 32'd0);
  endtask

  logic [15:0] ah [0:99];
  logic [15:0] bh [0:99];
  logic [15:0] held, ed16;
  bit          have;
  int          last_i, ndone, dcount;

  initial begin
    rst_n = 1'b0;
    bus16.start = 1'b0; bus16.a = '0; bus16.b = '0;
    bus1.start  = 1'b0; bus1.a  = '0; bus1.b  = '0;
    #1;
    chk("rst_diff16", 32'(bus16.diff), 32'd0);
    chk("rst_borrow16", 32'(bus16.borrow_out), 32'd0);
    chk("rst_busy16", 32'(bus16.busy), 32'd0);
    chk("rst_done16", 32'(bus16.done), 32'd0);
    chk("rst_diff1", 32'(bus1.diff), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed operand pairs.
    run16(16'd5, 16'd3);
    run16(16'd3, 16'd5);
    run16(16'h0000, 16'h0001);
    run16(16'hFFFF, 16'hFFFF);

    // start held high with operands changing every cycle.
    @(negedge clk);
    have = 1'b0; last_i = -1; ndone = 0; held = '0;
    for (int i = 0; i < 100; i++) begin
      ah[i] = 16'($urandom); bh[i] = 16'($urandom);
      bus16.start = 1'b1; bus16.a = ah[i]; bus16.b = bh[i];
      @(negedge clk);
      if (bus16.done === 1'b1) begin
        ndone++;
        if (last_i >= 0) chk("cont_spacing", 32'(i - last_i), 32'd18);
        else             chk("cont_first", 32'(i), 32'd15 + 32'd1);
        if (i >= 16) begin
          ed16 = ah[i-16] - bh[i-16];
          chk("cont_diff", 32'(bus16.diff), 32'(ed16));
          chk("cont_borrow", 32'(bus16.borrow_out), 32'(ah[i-16] < bh[i-16]));
        end
        last_i = i; held = bus16.diff; have = 1'b1;
      end else if (have) begin
        chk("cont_hold", 32'(bus16.diff), 32'(held));
      end
    end
    bus16.start = 1'b0;
    chk("cont_ndone", 32'(ndone), 32'd5);
    repeat (25) @(negedge clk);

    // Reset in the middle of an operation.
    @(negedge clk);
    bus16.start = 1'b1; bus16.a = 16'd100; bus16.b = 16'd1;
    @(negedge clk);
    bus16.start = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid_busy_before", 32'(bus16.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_diff", 32'(bus16.diff), 32'd0);
    chk("mid_rst_borrow", 32'(bus16.borrow_out), 32'd0);
    chk("mid_rst_busy", 32'(bus16.busy), 32'd0);
    chk("mid_rst_done", 32'(bus16.done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus16.done === 1'b1) dcount++;
    end
    chk("mid_no_done", 32'(dcount), 32'd0);
    run16(16'd100, 16'd1);

    // Random regression at both widths.
    for (int i = 0; i < 1000; i++) run16(16'($urandom), 16'($urandom));
    run1(1'b0, 1'b1);
    run1(1'b1, 1'b1);
    for (int i = 0; i < 1000; i++) run1(1'($urandom), 1'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial subtractor computing diff = a - b, LSB first, one bit per clock through a single full-adder cell. The b operand is inverted and carry-in is forced to 1.
- Inverse-operation counterpart to the team's parallel ripple-carry adder. Trades n cycles of latency for one adder cell.
- Sits behind a start/busy/done handshake so a controller can issue back-to-back operations.

Parameters:
n, 16, operand and result width in bits (n >= 1)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  request; sampled only in IDLE
a  input  n  minuend; captured on the accepted start edge
b  input  n  subtrahend; captured on the accepted start edge
diff  output  n  result (a - b) mod 2^n; registered, held until next completion
borrow_out  output  1  1 when a < b (unsigned); registered, held with diff
busy  output  1  high while the operation is in progress (SHIFT state)
done  output  1  one-cycle pulse when diff/borrow_out become valid

Behaviour:
- Reset: rst_n low asynchronously forces state=IDLE, diff=0, borrow_out=0, busy=0, done=0, and clears internal regs.
- Reset mid-operation: the operation is aborted, no done pulse is produced, and outputs return to their reset values.
- States:
  - IDLE: busy=0, done=0. On start=1 at edge E0: load sa<=a, sb<=b, c<=1, cnt<=0; go to SHIFT.
  - SHIFT: busy=1. Each edge computes s = sa[0] ^ ~sb[0] ^ c and c <= maj(sa[0], ~sb[0], c).
    - sa and sb shift right by 1.
    - sr (n-bit result shift register) shifts right with s into the MSB.
    - cnt increments.
    - On the edge where cnt==n-1: load diff <= final sr (including this bit), borrow_out <= ~c_next; go to DONE.
  - DONE: done=1, busy=0 for exactly one cycle. The next edge always returns to IDLE.
- Latency: start accepted at E0, last bit processed at En, done high in the cycle following En (n cycles after acceptance).
- Throughput: one operation per n+2 cycles.
- start while busy or in DONE is ignored, not queued. The captured operands are unaffected by a/b changes after E0.
- diff and borrow_out change only on the completion edge and are stable otherwise, including during the next operation.
- n=1: SHIFT lasts one edge; the operation is otherwise identical.
- Arithmetic: all unsigned. diff wraps mod 2^n. Equal operands give diff=0, borrow_out=0.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and a counter-width function clog2(n) for cnt.
- One sub-module: the team's existing 1-bit full_adder cell, instanced once with inputs (sa[0], ~sb[0], c).
- Everything else (FSM, shift registers, counter) lives in serial_subtractor.

Test Plan:
- n=16, a=5, b=3, start pulse -> busy high for 16 cycles, then done pulse; diff=0x0002, borrow_out=0.
- a=3, b=5 -> diff=0xFFFE, borrow_out=1.
- a=0x0000, b=0x0001 -> diff=0xFFFF, borrow_out=1. Then a=0xFFFF, b=0xFFFF -> diff=0x0000, borrow_out=0.
- start held high continuously with a/b changing every cycle -> each result matches the operands present at its accepting edge. Exactly one done per n+2 cycles; diff is unchanged between done pulses.
- rst_n pulsed low at cycle 8 of an operation (a=100, b=1) -> outputs go to 0 immediately and no done pulse appears. A new start afterwards (a=100, b=1) -> diff=99, borrow_out=0.
- Random regression, 1000 operand pairs, n=16 and n=1 -> diff==(a-b) mod 2^n and borrow_out==(a<b) for every done pulse.
